// File: rtl/risc_seq_ctrl.sv
// Sequencer for a tiny two-register RISC datapath: a 16-word program store,
// fetch/step/execute control and decoded datapath strobes.
module risc_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [3:0]       load_addr,
  input  logic [7:0]       load_data,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic [3:0]       pc,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic             rf_waddr,
  output logic             rf_wsel,
  output logic [3:0]       imm,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       imem [16];
  logic [7:0]       ir, ir_nx;
  logic [3:0]       pc_nx;
  logic [CNT_W-1:0] retired_nx;
  logic [3:0]       opcode;

  assign opcode = ir[7:4];
  assign imm    = ir[3:0];

  always_comb begin
    load_ready = (state == S_IDLE) || (state == S_HALTED);
    busy       = (state == S_FETCH) || (state == S_WAIT) || (state == S_EXEC);
    halted     = (state == S_HALTED);
  end

  // Program store has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (rst && load_valid && load_ready) begin
      imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      ir      <= ir_nx;
      retired <= retired_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_nx      = ir;
    retired_nx = retired;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nx   = S_FETCH;
          pc_nx      = '0;
          retired_nx = '0;
        end
      end
      S_FETCH: begin
        ir_nx    = imem[pc];
        state_nx = step_mode ? S_WAIT : S_EXEC;
      end
      S_WAIT: begin
        if (step) begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        retired_nx = retired + CNT_W'(1);
        state_nx   = S_FETCH;
        case (opcode)
          4'h6:    pc_nx = ir[3:0];
          4'h7:    state_nx = S_HALTED;
          default: pc_nx = pc + 4'd1;
        endcase
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath strobes are only meaningful during the single EXEC cycle.
  always_comb begin
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    rf_waddr = 1'b0;
    alu_op   = 2'd0;
    if (state == S_EXEC) begin
      case (opcode)
        4'h0, 4'h1, 4'h2, 4'h3: begin
          rf_we  = 1'b1;
          alu_op = opcode[1:0];
        end
        4'h4: begin
          rf_we    = 1'b1;
          rf_wsel  = 1'b1;
          rf_waddr = ir[2];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Scoreboard bench for risc_seq_ctrl: a program-level reference model queues
// the expected effect of every executed instruction; a monitor checks them.
module tb_risc_seq_ctrl;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [3:0]       load_addr = '0;
  logic [7:0]       load_data = '0;
  logic             start = 1'b0;
  logic             step_mode = 1'b0;
  logic             step = 1'b0;
  logic [3:0]       pc;
  logic [1:0]       alu_op;
  logic             rf_we;
  logic             rf_waddr;
  logic             rf_wsel;
  logic [3:0]       imm;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;

  risc_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .step_mode(step_mode), .step(step),
    .pc(pc), .alu_op(alu_op), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wsel(rf_wsel), .imm(imm), .busy(busy), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pc_b;
    logic       we;
    logic       wsel;
    logic       waddr;
    logic [1:0] alu;
    logic [3:0] imm;
    logic [3:0] pc_a;
    logic       halt_a;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [16];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: walk the program from pc 0 by instruction semantics.
  task automatic model_push(input int k, output int n, output bit h);
    logic [3:0] p;
    logic [7:0] w;
    exp_t       e;
    p = 4'd0;
    n = 0;
    h = 1'b0;
    while (n < k && !h) begin
      w        = mem[p];
      e.pc_b   = p;
      e.imm    = w[3:0];
      e.we     = 1'b0;
      e.wsel   = 1'b0;
      e.waddr  = 1'b0;
      e.alu    = 2'd0;
      e.halt_a = 1'b0;
      e.pc_a   = 4'((int'(p) + 1) % 16);
      case (w[7:4])
        0, 1, 2, 3: begin e.we = 1'b1; e.alu = w[5:4]; end
        4:          begin e.we = 1'b1; e.wsel = 1'b1; e.waddr = w[2]; end
        6:          e.pc_a = w[3:0];
        7:          begin e.pc_a = p; e.halt_a = 1'b1; h = 1'b1; end
        default:    ;
      endcase
      exp_q.push_back(e);
      p = e.pc_a;
      n++;
    end
  endtask

  // Monitor: a cycle was EXEC exactly when retired advanced by one across it.
  logic             s_valid = 1'b0;
  logic [3:0]       s_pc, s_imm;
  logic             s_we, s_wsel, s_waddr;
  logic [1:0]       s_alu;
  logic [CNT_W-1:0] s_ret;
  logic             rst_e;

  always @(posedge clk) rst_e <= rst;

  always @(negedge clk) begin
    exp_t e;
    if (s_valid && rst_e === 1'b1) begin
      if (retired === s_ret + CNT_W'(1)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_exec: got instruction at pc 0x%0h, expected none", s_pc);
        end else begin
          e = exp_q.pop_front();
          chk("exec_pc", s_pc, e.pc_b);
          chk("exec_rf_we", s_we, e.we);
          if (e.we) begin
            chk("exec_rf_wsel", s_wsel, e.wsel);
            chk("exec_rf_waddr", s_waddr, e.waddr);
            if (!e.wsel) chk("exec_alu_op", s_alu, e.alu);
          end
          chk("exec_imm", s_imm, e.imm);
          chk("next_pc", pc, e.pc_a);
          chk("next_halted", halted, e.halt_a);
        end
      end else begin
        chk("idle_rf_we", s_we, 1'b0);
      end
    end
    s_valid = 1'b1;
    s_pc    = pc;
    s_imm   = imm;
    s_we    = rf_we;
    s_wsel  = rf_wsel;
    s_waddr = rf_waddr;
    s_alu   = alu_op;
    s_ret   = retired;
  end

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    mem[a]     = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic run_prog(input int k, input bit sm, input bit noise, input int na,
                          input bit sl, input logic [3:0] sla, input logic [7:0] sld);
    int n;
    bit h;
    int budget;
    @(negedge clk);
    if (sl) begin
      load_valid = 1'b1;
      load_addr  = sla;
      load_data  = sld;
      mem[sla]   = sld;
    end
    model_push(k, n, h);
    step_mode = sm;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    budget = n * (sm ? 16 : 4) + 20;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 || budget == 0) break;
      budget--;
      step = sm && ($urandom_range(0, 2) == 0);
      if (noise) begin
        chk("load_ready_vs_busy", load_ready, !busy);
        load_valid = busy && ($urandom_range(0, 1) == 1);
        load_addr  = (na < 0) ? 4'($urandom_range(0, 15)) : 4'(na);
        load_data  = 8'($urandom_range(0, 255));
        start      = busy && ($urandom_range(0, 7) == 0);
      end
    end
    step       = 1'b0;
    load_valid = 1'b0;
    start      = 1'b0;
    if (exp_q.size() != 0) begin
      chk("run_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      h = 1'b0;
    end else begin
      chk("retired_count", retired, n % (1 << CNT_W));
    end
    if (!h) begin
      rst = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit h;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc", pc, 4'd0);
    chk("rst_retired", retired, 0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
    rst = 1'b1;

    // LOAD r1,5 ; ADD ; HALT
    load_word(4'd0, 8'h45);
    load_word(4'd1, 8'h00);
    load_word(4'd2, 8'h70);
    run_prog(20, 1'b0, 1'b0, -1, 1'b0, 4'd0, 8'h00);
    chk("prog1_halted", halted, 1'b1);
    chk("prog1_pc", pc, 4'd2);
    chk("prog1_retired", retired, 3);

    // Restart from HALTED with a same-cycle load of word 1
    run_prog(20, 1'b0, 1'b0, -1, 1'b1, 4'd1, 8'h13);
    chk("restart_retired", retired, 3);

    // Jump to 15, NOP at 15 wraps pc to 0
    load_word(4'd0, 8'h6F);
    load_word(4'd15, 8'h80);
    run_prog(6, 1'b0, 1'b0, -1, 1'b0, 4'd0, 8'h00);
    chk("wrap_idle_pc", pc, 4'd0);

    // Step mode: holds in WAIT until step
    load_word(4'd0, 8'h00);
    load_word(4'd1, 8'h21);
    load_word(4'd2, 8'h70);
    @(negedge clk);
    model_push(10, n, h);
    step_mode = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("wait_busy", busy, 1'b1);
    chk("wait_pc", pc, 4'd0);
    chk("wait_retired", retired, 0);
    chk("wait_rf_we", rf_we, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      chk("step_retired", retired, i + 1);
    end
    chk("step_halted", halted, 1'b1);
    chk("step_queue_drained", exp_q.size(), 0);
    step_mode = 1'b0;

    // Loads to word 3 while busy must be dropped; word 3 (HALT) read back by running
    load_word(4'd0, 8'h12);
    load_word(4'd1, 8'h23);
    load_word(4'd2, 8'h80);
    load_word(4'd3, 8'h70);
    run_prog(20, 1'b0, 1'b1, 3, 1'b0, 4'd0, 8'h00);
    run_prog(20, 1'b0, 1'b0, -1, 1'b0, 4'd0, 8'h00);
    chk("readback_pc", pc, 4'd3);
    chk("readback_halted", halted, 1'b1);

    // Reset during EXEC of an ADD, then rerun
    load_word(4'd0, 8'h00);
    load_word(4'd1, 8'h10);
    load_word(4'd2, 8'h70);
    @(negedge clk);
    step_mode = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midexec_rf_we", rf_we, 1'b1);
    chk("midexec_alu_op", alu_op, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pc", pc, 4'd0);
    chk("midrst_rf_we", rf_we, 1'b0);
    chk("midrst_retired", retired, 0);
    chk("midrst_load_ready", load_ready, 1'b1);
    run_prog(20, 1'b0, 1'b0, -1, 1'b0, 4'd0, 8'h00);
    chk("rerun_pc", pc, 4'd2);

    // Retired counter wraps on a tight loop
    load_word(4'd0, 8'h00);
    load_word(4'd1, 8'h60);
    run_prog(260, 1'b0, 1'b0, -1, 1'b0, 4'd0, 8'h00);

    // Random programs, random step timing, load/start noise while busy
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 16; a++) begin
        load_word(4'(a), 8'($urandom_range(0, 255)));
      end
      run_prog(30, 1'($urandom_range(0, 1)), 1'b1, -1, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
